// File: rtl/spi_master_mc_if.sv
// Front-end bus of the SPI master: transfer request, runtime config, received word.
interface spi_master_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CS     = 4,
  parameter int DIV_W      = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [1:0]            mode;
  logic [DIV_W-1:0]      clk_div;
  logic                  lsb_first;
  logic [CS_W-1:0]       cs_sel;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;

  modport master (
    output tx_valid, tx_data, mode, clk_div, lsb_first, cs_sel,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, mode, clk_div, lsb_first, cs_sel,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_master_mc.sv
// Full-duplex SPI master: runtime mode/divider/bit order, one-hot active-low chip selects.
// Data is always shifted MSB-side internally; LSB-first is handled by mirroring
// the word on the way in and on the way out.
module spi_master_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CS     = 4,
  parameter int DIV_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_mc_if.slave    bus,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int NT   = 2 * DATA_WIDTH;
  localparam int TC_W = $clog2(NT + 1);

  typedef enum logic [1:0] {IDLE, START_TX, TRANSMIT, END_TX} state_t;

  // transfer settings frozen at acceptance
  typedef struct packed {
    logic             cpha;
    logic [DIV_W-1:0] div;
    logic             lsb;
  } cfg_t;

  state_t                state, state_nxt;
  cfg_t                  cfg;
  logic [DIV_W-1:0]      cnt;
  logic [TC_W-1:0]       tcnt;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh, tx_ord, rx_ord, rx_data_q;
  logic [NUM_CS-1:0]     cs_dec;
  logic                  accept, tick, toggle, leading, last_tgl;
  logic                  do_drive, do_sample, done, rx_valid_q;

  function automatic logic [DATA_WIDTH-1:0] rev(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
    return r;
  endfunction

  assign bus.tx_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

  // chip-select decode and bit-order mirroring; out-of-range cs_sel selects nothing
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (bus.cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    tx_ord = bus.lsb_first ? rev(bus.tx_data) : bus.tx_data;
    rx_ord = cfg.lsb ? rev(rx_sh) : rx_sh;
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // next state and per-cycle strobes; tcnt counts toggles already made
  always_comb begin
    state_nxt = state;
    toggle    = 1'b0;
    done      = 1'b0;
    accept    = bus.tx_valid && (state == IDLE);
    tick      = (cnt == cfg.div);
    case (state)
      IDLE:     if (accept) state_nxt = START_TX;
      START_TX: if (tick) begin state_nxt = TRANSMIT; toggle = 1'b1; end
      TRANSMIT: if (tick) begin
                  if (tcnt == TC_W'(NT)) state_nxt = END_TX;
                  else                   toggle    = 1'b1;
                end
      END_TX:   if (tick) begin state_nxt = IDLE; done = 1'b1; end
      default:  state_nxt = IDLE;
    endcase
    leading   = ~tcnt[0];
    last_tgl  = (tcnt == TC_W'(NT - 1));
    // CPHA=0 samples on leading, drives on trailing; CPHA=1 the other way round
    do_sample = toggle && (leading ^ cfg.cpha);
    do_drive  = toggle && (cfg.cpha ? leading : (!leading && !last_tgl));
  end

  // datapath: divider, sclk, shift registers, chip selects, result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cfg        <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= done;
      cnt        <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        sclk <= bus.mode[1];
        mosi <= 1'b0;
        cs_n <= '1;
        if (accept) begin
          cfg  <= '{cpha: bus.mode[0], div: bus.clk_div, lsb: bus.lsb_first};
          tcnt <= '0;
          cs_n <= cs_dec;
          // CPHA=0 presents the first bit before the first edge
          if (bus.mode[0]) tx_sh <= tx_ord;
          else begin
            mosi  <= tx_ord[DATA_WIDTH-1];
            tx_sh <= tx_ord << 1;
          end
        end
      end else begin
        if (toggle) begin
          sclk <= ~sclk;
          tcnt <= tcnt + 1'b1;
        end
        if (do_sample) rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso};
        if (do_drive) begin
          mosi  <= tx_sh[DATA_WIDTH-1];
          tx_sh <= tx_sh << 1;
        end
        if (done) begin
          cs_n      <= '1;
          mosi      <= 1'b0;
          rx_data_q <= rx_ord;
        end
      end
    end
endmodule

// File: tb/tb_spi_master_mc.sv
// Randomised bench for spi_master_mc: an SPI slave model driven from the pins,
// transfer-level expectations (latency, words, edge counts) from protocol rules.
module tb_spi_master_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_mc_if #(.DATA_WIDTH(8),  .NUM_CS(4), .DIV_W(8)) b8();
  spi_master_mc_if #(.DATA_WIDTH(32), .NUM_CS(4), .DIV_W(8)) b32();

  logic       sclk8, mosi8, miso8, slv_miso, loop;
  logic [3:0] csn8;
  logic       sclk32, mosi32, miso32;
  logic [3:0] csn32;

  assign miso8  = loop ? mosi8 : slv_miso;
  assign miso32 = mosi32;

  spi_master_mc #(.DATA_WIDTH(8), .NUM_CS(4), .DIV_W(8)) u8 (
    .clk(clk), .rst(rst), .bus(b8), .sclk(sclk8), .mosi(mosi8), .miso(miso8), .cs_n(csn8));
  spi_master_mc #(.DATA_WIDTH(32), .NUM_CS(4), .DIV_W(8)) u32 (
    .clk(clk), .rst(rst), .bus(b32), .sclk(sclk32), .mosi(mosi32), .miso(miso32), .cs_n(csn32));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave model state / monitor counters
  logic       s_cpol, s_cpha, s_lsb;
  logic [7:0] s_word, s_rx;
  logic [3:0] exp_csn;
  int rises8, bad_mosi, bad_cs, rxv8;
  int rises32, bad_per, cyc, last_rise;

  function automatic logic bitv(input logic [7:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[7-i];
  endfunction

  // SPI slave (mode/order configured by the bench) plus protocol monitors
  initial begin
    logic pact, psclk, pmosi, act, lead, p32;
    int si, ri;
    pact = 0; psclk = 0; pmosi = 0; p32 = 0; si = 0; ri = 0;
    slv_miso = 0; cyc = 0; last_rise = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (b8.rx_valid) rxv8++;
      act = (csn8 != 4'hF) && !rst;
      if (act && !pact) begin
        si = 0; ri = 0; s_rx = 0;
        if (!s_cpha) slv_miso = bitv(s_word, 0, s_lsb);
      end else if (act && sclk8 != psclk) begin
        lead = (sclk8 != s_cpol);
        if (sclk8) rises8++;
        if (lead ^ s_cpha) begin
          if (ri < 8) s_rx[s_lsb ? ri : 7 - ri] = mosi8;
          ri++;
        end else if (s_cpha) begin
          if (si < 8) slv_miso = bitv(s_word, si, s_lsb);
          si++;
        end else begin
          si++;
          if (si < 8) slv_miso = bitv(s_word, si, s_lsb);
        end
      end
      if (act && pact && s_cpha && mosi8 != pmosi && !(sclk8 != psclk && sclk8 != s_cpol))
        bad_mosi++;
      if (csn8 != 4'hF && csn8 != exp_csn) bad_cs++;
      pact = act; psclk = sclk8; pmosi = mosi8;
      if (csn32 == 4'hF) last_rise = -1;
      else if (sclk32 && !p32) begin
        if (last_rise >= 0 && cyc - last_rise != 2) bad_per++;
        last_rise = cyc;
        rises32++;
      end
      p32 = sclk32;
    end
  end

  task automatic wait_rx8(output int n);
    n = 0;
    while (!b8.rx_valid && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rx_valid_seen", b8.rx_valid, 1'b1);
  endtask

  task automatic xfer8(input logic [7:0] d, input logic [1:0] md, input logic [7:0] dv,
                       input logic lsb, input logic [1:0] cs, input logic [7:0] sw,
                       input logic lp, input logic scramble);
    int n;
    logic [7:0] exp_rx;
    @(negedge clk);
    b8.tx_data = d; b8.mode = md; b8.clk_div = dv; b8.lsb_first = lsb; b8.cs_sel = cs;
    s_cpol = md[1]; s_cpha = md[0]; s_lsb = lsb; s_word = sw; loop = lp;
    exp_csn = ~(4'b0001 << cs);
    rises8 = 0; bad_mosi = 0; bad_cs = 0;
    @(negedge clk);
    chk("idle_sclk", sclk8, md[1]);
    chk("idle_ready", b8.tx_ready, 1'b1);
    b8.tx_valid = 1'b1;
    @(posedge clk); #1;
    b8.tx_valid = 1'b0;
    chk("busy", b8.busy, 1'b1);
    if (scramble) begin
      b8.tx_data = 8'($urandom); b8.mode = 2'($urandom); b8.clk_div = 8'($urandom_range(0, 3));
      b8.lsb_first = 1'($urandom); b8.cs_sel = 2'($urandom);
    end
    wait_rx8(n);
    exp_rx = lp ? d : sw;
    chk("latency", n, (2 * 8 + 2) * (dv + 1));
    chk("rx_data", b8.rx_data, exp_rx);
    chk("ready_w_valid", b8.tx_ready, 1'b1);
    chk("cs_released", csn8, 4'hF);
    chk("mosi_stream", s_rx, d);
    chk("sclk_rises", rises8, 8);
    chk("cpha1_mosi", bad_mosi, 0);
    chk("cs_onehot", bad_cs, 0);
    @(posedge clk); #1;
    chk("rx_pulse", b8.rx_valid, 1'b0);
  endtask

  initial begin
    int n, tg, g, r0;
    logic ps;
    b8.tx_valid = 0; b8.tx_data = 0; b8.mode = 0; b8.clk_div = 0; b8.lsb_first = 0; b8.cs_sel = 0;
    b32.tx_valid = 0; b32.tx_data = 0; b32.mode = 0; b32.clk_div = 0; b32.lsb_first = 0; b32.cs_sel = 0;
    s_cpol = 0; s_cpha = 0; s_lsb = 0; s_word = 0; loop = 1; exp_csn = 4'hE;
    rises8 = 0; bad_mosi = 0; bad_cs = 0; rxv8 = 0; rises32 = 0; bad_per = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", b8.tx_ready, 1'b1);
    chk("rst_busy", b8.busy, 1'b0);
    chk("rst_rxv", b8.rx_valid, 1'b0);
    chk("rst_rxd", b8.rx_data, 8'h00);
    chk("rst_sclk", sclk8, 1'b0);
    chk("rst_mosi", mosi8, 1'b0);
    chk("rst_csn", csn8, 4'hF);
    @(negedge clk); rst = 1'b0;

    // directed: mode 0 loopback, modes 1-3, LSB-first against slave
    xfer8(8'hA5, 2'd0, 8'd1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    for (int m = 1; m < 4; m++) xfer8(8'h3C, 2'(m), 8'd1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    xfer8(8'h01, 2'd0, 8'd1, 1'b1, 2'd0, 8'h80, 1'b0, 1'b0);

    // randomised transfers, inputs scrambled while in flight
    for (int k = 0; k < 12; k++)
      xfer8(8'($urandom), 2'($urandom), 8'($urandom_range(0, 3)), 1'($urandom),
            2'($urandom), 8'($urandom), 1'($urandom), 1'b1);

    // back-to-back with tx_valid held high: cs 2 then cs 3
    @(negedge clk);
    b8.tx_data = 8'($urandom); b8.mode = 0; b8.clk_div = 0; b8.lsb_first = 0; b8.cs_sel = 2;
    s_cpol = 0; s_cpha = 0; s_lsb = 0; loop = 1; exp_csn = 4'b1011; bad_cs = 0;
    r0 = rxv8;
    b8.tx_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_cs2", csn8, 4'b1011);
    b8.cs_sel = 3;
    wait_rx8(n);
    chk("b2b_gap", csn8, 4'hF);
    exp_csn = 4'b0111;
    @(posedge clk); #1;
    chk("b2b_cs3", csn8, 4'b0111);
    b8.tx_valid = 1'b0;
    wait_rx8(n);
    @(negedge clk);
    chk("b2b_pulses", rxv8 - r0, 2);
    chk("b2b_onehot", bad_cs, 0);

    // reset at the 5th sclk toggle
    b8.tx_data = 8'($urandom); b8.mode = 0; b8.clk_div = 1; b8.cs_sel = 1; exp_csn = 4'b1101;
    b8.tx_valid = 1'b1;
    @(posedge clk); #1;
    b8.tx_valid = 1'b0;
    tg = 0; g = 0; ps = sclk8;
    while (tg < 5 && g < 1000) begin
      @(posedge clk); #1;
      g++;
      if (sclk8 != ps) tg++;
      ps = sclk8;
    end
    chk("rst_toggles", tg, 5);
    rst = 1'b1;
    #1;
    chk("abort_csn", csn8, 4'hF);
    chk("abort_sclk", sclk8, 1'b0);
    chk("abort_busy", b8.busy, 1'b0);
    r0 = rxv8;
    @(negedge clk); rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_rxv", rxv8 - r0, 0);
    xfer8(8'h96, 2'd2, 8'd0, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0);

    // 32-bit, clk_div 0, inputs changed mid-transfer
    @(negedge clk);
    b32.tx_data = 32'hDEADBEEF; b32.mode = 0; b32.clk_div = 0; b32.lsb_first = 0; b32.cs_sel = 0;
    rises32 = 0; bad_per = 0;
    b32.tx_valid = 1'b1;
    @(posedge clk); #1;
    b32.tx_valid = 1'b0;
    b32.tx_data = $urandom; b32.mode = 2'd3; b32.clk_div = 8'd5; b32.lsb_first = 1; b32.cs_sel = 3;
    n = 0;
    while (!b32.rx_valid && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w32_seen", b32.rx_valid, 1'b1);
    chk("w32_latency", n, 66);
    chk("w32_rx", b32.rx_data, 32'hDEADBEEF);
    chk("w32_rises", rises32, 32);
    chk("w32_period", bad_per, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
